// File: rtl/pci_reg_arb.sv
// pci_reg_arb: four-requester arbiter onto one shared register port.
// Define PCI_REG_ARB_RR_EN for round-robin; default is fixed priority (0 highest).
module pci_reg_arb #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            pci_req,
  input  logic [3:0]            pci_wr,
  input  logic [4*ADDR_W-1:0]   pci_addr,
  input  logic [4*DATA_W-1:0]   pci_wdata,
  output logic [3:0]            pci_ack,
  output logic [DATA_W-1:0]     pci_rdata,
  output logic                  reg_sel,
  output logic                  reg_wr,
  output logic [ADDR_W-1:0]     reg_addr,
  output logic [DATA_W-1:0]     reg_wdata,
  input  logic [DATA_W-1:0]     reg_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  state_t              state_q, state_d;
  logic [1:0]          g_q, g_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                sel_q, sel_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [1:0]          win;
  logic                win_vld;

`ifdef PCI_REG_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;

  // Round-robin search starting at the pointer; lowest offset wins.
  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    idx     = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (pci_req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end
`else
  // Fixed priority: lowest requester index wins.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (pci_req[k]) begin
        win     = 2'(k);
        win_vld = 1'b1;
      end
    end
  end
`endif

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    ack_d   = 4'b0000;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PCI_REG_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          g_d     = win;
          wr_d    = pci_wr[win];
          addr_d  = pci_addr[int'(win)*ADDR_W +: ADDR_W];
          wdata_d = pci_wdata[int'(win)*DATA_W +: DATA_W];
          sel_d   = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
`ifdef PCI_REG_ARB_RR_EN
          ptr_d   = win + 2'd1;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) rdata_d = reg_rdata;
          sel_d   = 1'b0;
          wr_d    = 1'b0;
          ack_d   = 4'b0001 << g_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= 2'd0;
      cnt_q   <= 4'd0;
      ack_q   <= 4'b0000;
      rdata_q <= '0;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef PCI_REG_ARB_RR_EN
  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign pci_ack   = ack_q;
  assign pci_rdata = rdata_q;
  assign reg_sel   = sel_q;
  assign reg_wr    = wr_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;

endmodule

// File: tb/tb_pci_reg_arb.sv
// tb_pci_reg_arb: directed stimulus, transaction-level model checked every cycle.
// Honours PCI_REG_ARB_RR_EN for the contention expectations.
module tb_pci_reg_arb;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    pci_req = '0;
  logic [3:0]    pci_wr = '0;
  logic [4*AW-1:0] pci_addr = '0;
  logic [4*DW-1:0] pci_wdata = '0;
  logic [3:0]    pci_ack;
  logic [DW-1:0] pci_rdata;
  logic          reg_sel;
  logic          reg_wr;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata = '0;

  int checks = 0;
  int errors = 0;

  pci_reg_arb #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst),
    .pci_req(pci_req), .pci_wr(pci_wr),
    .pci_addr(pci_addr), .pci_wdata(pci_wdata),
    .pci_ack(pci_ack), .pci_rdata(pci_rdata),
    .reg_sel(reg_sel), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: one access = grant at t0, select t0+1..t0+W, ack t0+W+1.
  int            cyc = 0;
  bit            busy = 0;
  int            t0 = 0;
  int            mg = 0;
  bit            m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  int            ptr = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    = 0;
      m_rdata = '0;
      ptr     = 0;
    end else begin
      if (busy && cyc == t0 + W && !m_wr) m_rdata = reg_rdata;
      if (busy && cyc == t0 + W + 1) begin
        busy = 0;
      end else if (!busy && pci_req != 4'b0) begin
        for (int k = 3; k >= 0; k--)
          if (pci_req[(ptr + k) % 4]) mg = (ptr + k) % 4;
`ifdef PCI_REG_ARB_RR_EN
        ptr = (mg + 1) % 4;
`endif
        busy    = 1;
        t0      = cyc;
        m_wr    = pci_wr[mg];
        m_addr  = pci_addr[mg*AW +: AW];
        m_wdata = pci_wdata[mg*DW +: DW];
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    bit         e_sel;
    logic [3:0] e_ack;
    e_sel = !rst && busy && cyc >= t0 + 1 && cyc <= t0 + W;
    e_ack = (!rst && busy && cyc == t0 + W + 1) ? (4'b0001 << mg) : 4'b0;
    chk("m_sel", 64'(reg_sel), 64'(e_sel));
    chk("m_wr", 64'(reg_wr), 64'(e_sel && m_wr));
    chk("m_ack", 64'(pci_ack), 64'(e_ack));
    chk("m_rdata", 64'(pci_rdata), 64'(m_rdata));
    if (e_sel) begin
      chk("m_addr", 64'(reg_addr), 64'(m_addr));
      chk("m_wdata", 64'(reg_wdata), 64'(m_wdata));
    end
  end

  // Ack recorder for the contention run.
  bit rec = 0;
  int ncyc = 0;
  int ack_who[$];
  int ack_when[$];

  always @(negedge clk) begin
    ncyc++;
    if (rec && pci_ack != 4'b0)
      for (int i = 0; i < 4; i++)
        if (pci_ack[i]) begin
          ack_who.push_back(i);
          ack_when.push_back(ncyc);
        end
  end

  initial begin
    int exp_who;
    int n3;
    for (int i = 0; i < 4; i++) begin
      pci_addr[i*AW +: AW]  = AW'(8'hA0 + i);
      pci_wdata[i*DW +: DW] = DW'(32'h1000_0000 * (i + 1));
    end
    pci_addr[3*AW +: AW] = 8'h77;

    // Reset state
    tick();
    tick();
    chk("rst_ack", 64'(pci_ack), 64'h0);
    chk("rst_sel", 64'(reg_sel), 64'h0);
    chk("rst_wr", 64'(reg_wr), 64'h0);
    chk("rst_addr", 64'(reg_addr), 64'h0);
    chk("rst_wdata", 64'(reg_wdata), 64'h0);
    chk("rst_rdata", 64'(pci_rdata), 64'h0);
    rst = 1'b0;
    tick();

    // Single write from requester 1
    pci_req = 4'b0010;
    pci_wr  = 4'b0010;
    pci_addr[1*AW +: AW]  = 8'h3C;
    pci_wdata[1*DW +: DW] = 32'hDEADBEEF;
    tick();
    chk("w_sel1", 64'({reg_sel, reg_wr}), 64'h3);
    chk("w_addr", 64'(reg_addr), 64'h3C);
    chk("w_data", 64'(reg_wdata), 64'hDEADBEEF);
    tick();
    chk("w_sel2", 64'({reg_sel, reg_wr}), 64'h3);
    tick();
    chk("w_ack", 64'(pci_ack), 64'b0010);
    chk("w_sel_off", 64'({reg_sel, reg_wr}), 64'h0);
    pci_req = 4'b0;
    pci_wr  = 4'b0;
    tick();
    chk("w_ack_once", 64'(pci_ack), 64'h0);

    // Single read from requester 2
    pci_req = 4'b0100;
    pci_addr[2*AW +: AW] = 8'h10;
    tick();
    chk("r_sel", 64'({reg_sel, reg_wr}), 64'h2);
    chk("r_addr", 64'(reg_addr), 64'h10);
    reg_rdata = 32'hBAD0BAD0;
    tick();
    chk("r_wr_low", 64'(reg_wr), 64'h0);
    reg_rdata = 32'h12345678;
    tick();
    chk("r_ack", 64'(pci_ack), 64'b0100);
    chk("r_rdata", 64'(pci_rdata), 64'h12345678);
    pci_req   = 4'b0;
    reg_rdata = 32'h0;
    tick();

    // Requester 3 drops its request on the first select cycle
    pci_req = 4'b1000;
    tick();
    chk("d_sel", 64'(reg_sel), 64'h1);
    pci_req = 4'b0;
    tick();
    tick();
    chk("d_ack", 64'(pci_ack), 64'b1000);
    tick();
    chk("d_ack_once", 64'(pci_ack), 64'h0);
    tick();
    chk("d_no_new", 64'({reg_sel, pci_ack}), 64'h0);

    // Contention: all four held
    rec     = 1;
    pci_req = 4'b1111;
    repeat (24) tick();
    rec     = 0;
    pci_req = 4'b0;
    repeat (6) tick();
    chk("c_count", 64'(ack_who.size() >= 5), 64'h1);
    n3 = 0;
    for (int i = 0; i < ack_who.size(); i++) begin
      if (ack_who[i] == 3) n3++;
      if (i < 5) begin
`ifdef PCI_REG_ARB_RR_EN
        exp_who = i % 4;
`else
        exp_who = 0;
`endif
        chk($sformatf("c_who%0d", i), 64'(ack_who[i]), 64'(exp_who));
        if (i > 0)
          chk($sformatf("c_gap%0d", i),
              64'(ack_when[i] - ack_when[i-1]), 64'(W + 2));
      end
    end
`ifndef PCI_REG_ARB_RR_EN
    chk("c_no3", 64'(n3), 64'h0);
`endif

    // Reset on the second select cycle, request held across it
    pci_req = 4'b1100;
    tick();
    chk("x_sel", 64'(reg_sel), 64'h1);
    tick();
    rst = 1'b1;
    #1;
    chk("x_out0", 64'({pci_ack, reg_sel, reg_wr}), 64'h0);
    chk("x_addr0", 64'(reg_addr), 64'h0);
    chk("x_wd0", 64'(reg_wdata), 64'h0);
    chk("x_rd0", 64'(pci_rdata), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("x_new_sel", 64'(reg_sel), 64'h1);
    chk("x_new_addr", 64'(reg_addr), 64'h10);
    chk("x_no_ack1", 64'(pci_ack), 64'h0);
    tick();
    chk("x_no_ack2", 64'(pci_ack), 64'h0);
    tick();
    chk("x_ack", 64'(pci_ack), 64'b0100);
    pci_req = 4'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
